change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter PULSE_CYCLES, default 4: cycles each ejector solenoid output is held high per coin.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles from pulse end to coin-drop sensor before fault.
REQ-003 Parameter NICKEL_INIT, default 20: nickel inventory loaded at reset or refill.
REQ-004 Parameter DIME_INIT, default 20: dime inventory loaded at reset or refill.
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 change  in  3  change code from vending FSM: 0 none, 1 nickel, 2 dime, 3 nickel+dime, 4 two dimes, 5-7 invalid.
REQ-008 refill  in  1  one-cycle pulse; reload both inventories.
REQ-009 nickel_drop  in  1  nickel chute sensor, high one or more cycles per dropped coin.
REQ-010 dime_drop  in  1  dime chute sensor, same semantics.
REQ-011 eject_nickel  out  1  nickel solenoid drive.
REQ-012 eject_dime  out  1  dime solenoid drive.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 done  out  1  one-cycle pulse when a request finishes dispensing.
REQ-015 short_change  out  1  one-cycle pulse when a request cannot be paid from inventory.
REQ-016 overrun  out  1  sticky; nonzero change seen while busy.
REQ-017 fault  out  1  sticky; sensor timeout occurred.
REQ-018 nickel_count, dime_count  out  8 each  current inventories.

Function
REQ-019 States: IDLE, PULSE, WAIT, GAP, FAULT; single registered state machine.
REQ-020 Request accepted only in IDLE when change is nonzero; change sampled once, at acceptance.
REQ-021 Plan at acceptance: need_n/need_d = 1/0, 0/1, 1/1, 0/2 for codes 1-4.
REQ-022 Substitution: each dime lacking in inventory is replaced by two nickels; plan shall then require nickel_count >= need_n + 2*missing dimes.
REQ-023 Unpayable plan: short_change pulses in the cycle after acceptance, inventories unchanged, no ejection, state remains IDLE.
REQ-024 Invalid code 5-7 in IDLE: treated as unpayable (short_change pulse), nothing dispensed.
REQ-025 Dispense order: all nickels first, then all dimes; one coin at a time.
REQ-026 PULSE: selected eject output high for exactly PULSE_CYCLES cycles, then WAIT; other eject output low throughout.
REQ-027 WAIT: rising edge of matching drop sensor decrements that inventory by 1 and moves to GAP; non-matching sensor ignored.
REQ-028 WAIT: TIMEOUT cycles without matching edge -> FAULT; eject outputs low; fault set.
REQ-029 GAP lasts 1 cycle; next coin -> PULSE, else done pulses and state -> IDLE.
REQ-030 done and a new acceptance shall not occur in the same cycle; earliest new acceptance is the cycle after done.
REQ-031 Nonzero change while busy: request dropped, overrun set; no effect on current dispense.
REQ-032 refill in IDLE (and not FAULT): both counts reload to INIT values next cycle; refill outside IDLE ignored.
REQ-033 refill and nonzero change in same IDLE cycle: refill first, plan computed on reloaded counts.
REQ-034 Inventories never wrap: decrement at 0 is impossible by plan; counts saturate at 0.
REQ-035 FAULT: absorbing; only reset exits; busy high, eject outputs low.

Reset
REQ-036 Reset (any state, including mid-pulse): state IDLE, eject_nickel/eject_dime/done/short_change 0, overrun 0, fault 0, nickel_count NICKEL_INIT, dime_count DIME_INIT, timers cleared, in the following cycle.
REQ-037 Reset takes priority over refill, change and sensor inputs.

Verification
REQ-038 change=3, sensors answer 2 cycles after each pulse -> eject_nickel 4 cycles, then eject_dime 4 cycles; counts 19/19; one done pulse.
REQ-039 dime_count=0, nickel_count=20, change=4 -> four nickel ejections, nickel_count 16, dime_count 0, done once.
REQ-040 nickel_count=1, dime_count=0, change=2 -> short_change one cycle, no eject, counts unchanged, busy stays 0.
REQ-041 change=1, nickel_drop never asserted -> FAULT after 255 WAIT cycles, fault=1, busy=1, eject low until reset.
REQ-042 change=4 accepted, change=1 applied during first PULSE -> overrun=1, two dimes still dispensed, no nickel ejected.
REQ-043 Reset asserted mid-PULSE of change=3 -> eject outputs 0 next cycle, counts 20/20, state IDLE.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin change dispenser: plans a nickel/dime payout from inventory, then drives the
// ejector solenoids one coin at a time and confirms each coin on its chute sensor.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int TIMEOUT      = 255,
  parameter int NICKEL_INIT  = 20,
  parameter int DIME_INIT    = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] change,
  input  logic       refill,
  input  logic       nickel_drop,
  input  logic       dime_drop,
  output logic       eject_nickel,
  output logic       eject_dime,
  output logic       busy,
  output logic       done,
  output logic       short_change,
  output logic       overrun,
  output logic       fault,
  output logic [7:0] nickel_count,
  output logic [7:0] dime_count
);

  // state | meaning
  // IDLE  | waiting for a change request
  // PULSE | solenoid of the current coin held high
  // WAIT  | waiting for the matching chute sensor edge
  // GAP   | one-cycle pause between coins
  // FAULT | sensor timeout, left only by reset
  typedef enum logic [2:0] {S_IDLE, S_PULSE, S_WAIT, S_GAP, S_FAULT} state_t;

  localparam int TMAX = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic [2:0]    rem_n;
  logic [1:0]    rem_d;
  logic          nickel_q, dime_q;

  logic [7:0] n_eff, d_eff;
  logic [2:0] need_n, use_n;
  logic [1:0] need_d, miss_d, use_d;
  logic       code_ok, payable, accept;
  logic       cur_nickel, match_edge;

  // Plan on the counts as they will be after a same-cycle refill
  always_comb begin
    n_eff   = refill ? 8'(NICKEL_INIT) : nickel_count;
    d_eff   = refill ? 8'(DIME_INIT)   : dime_count;
    need_n  = 3'd0;
    need_d  = 2'd0;
    code_ok = 1'b1;
    case (change)
      3'd1: need_n = 3'd1;
      3'd2: need_d = 2'd1;
      3'd3: begin need_n = 3'd1; need_d = 2'd1; end
      3'd4: need_d = 2'd2;
      default: code_ok = 1'b0;
    endcase
    miss_d  = (d_eff < {6'd0, need_d}) ? (need_d - d_eff[1:0]) : 2'd0;
    use_d   = need_d - miss_d;
    use_n   = need_n + {miss_d, 1'b0};
    payable = code_ok && ({5'd0, use_n} <= n_eff);
    accept  = (state == S_IDLE) && (change != 3'd0);
  end

  assign cur_nickel = (rem_n != 3'd0);
  assign match_edge = cur_nickel ? (nickel_drop & ~nickel_q) : (dime_drop & ~dime_q);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept && payable) next_state = S_PULSE;
      S_PULSE: if (timer == '0) next_state = S_WAIT;
      S_WAIT: begin
        if (match_edge)         next_state = S_GAP;
        else if (timer == '0)   next_state = S_FAULT;
      end
      S_GAP:   next_state = (rem_n != 3'd0 || rem_d != 2'd0) ? S_PULSE : S_IDLE;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    eject_nickel = (state == S_PULSE) && cur_nickel;
    eject_dime   = (state == S_PULSE) && !cur_nickel;
    busy         = (state != S_IDLE);
    done         = (state == S_GAP) && (rem_n == 3'd0) && (rem_d == 2'd0);
    fault        = (state == S_FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer        <= '0;
      rem_n        <= 3'd0;
      rem_d        <= 2'd0;
      nickel_count <= 8'(NICKEL_INIT);
      dime_count   <= 8'(DIME_INIT);
      nickel_q     <= 1'b0;
      dime_q       <= 1'b0;
      short_change <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      nickel_q     <= nickel_drop;
      dime_q       <= dime_drop;
      short_change <= accept && !payable;
      if (state != S_IDLE && change != 3'd0) overrun <= 1'b1;
      if (state == S_IDLE && refill) begin
        nickel_count <= 8'(NICKEL_INIT);
        dime_count   <= 8'(DIME_INIT);
      end
      case (state)
        S_IDLE: if (accept && payable) begin
          rem_n <= use_n;
          rem_d <= use_d;
          timer <= TW'(PULSE_CYCLES - 1);
        end
        S_PULSE: timer <= (timer == '0) ? TW'(TIMEOUT - 1) : timer - 1'b1;
        S_WAIT: begin
          if (match_edge) begin
            if (cur_nickel) begin
              rem_n <= rem_n - 3'd1;
              if (nickel_count != 8'd0) nickel_count <= nickel_count - 8'd1;
            end else begin
              rem_d <= rem_d - 2'd1;
              if (dime_count != 8'd0) dime_count <= dime_count - 8'd1;
            end
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end
        end
        S_GAP: timer <= TW'(PULSE_CYCLES - 1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: coin-level payout model, sensor responder and
// per-cycle checks of pulse length, coin order and inventories.
module tb_change_dispenser;
  localparam int PULSE = 4;
  localparam int NI    = 20;
  localparam int DI    = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] change = 3'd0;
  logic       refill = 1'b0;
  logic       nickel_drop = 1'b0;
  logic       dime_drop = 1'b0;
  logic       eject_nickel, eject_dime, busy, done, short_change, overrun, fault;
  logic [7:0] nickel_count, dime_count;

  change_dispenser #(.PULSE_CYCLES(PULSE), .TIMEOUT(255), .NICKEL_INIT(NI), .DIME_INIT(DI)) dut (
    .clock(clock), .reset(reset), .change(change), .refill(refill),
    .nickel_drop(nickel_drop), .dime_drop(dime_drop),
    .eject_nickel(eject_nickel), .eject_dime(eject_dime), .busy(busy), .done(done),
    .short_change(short_change), .overrun(overrun), .fault(fault),
    .nickel_count(nickel_count), .dime_count(dime_count)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int m_n = NI, m_d = DI;
  int exp_q[$];
  int exp_done = 0, exp_short = 0, done_cnt = 0, short_cnt = 0;
  int run_n = 0, run_d = 0;
  bit resp_en = 1'b1;
  bit pe_n = 1'b0, pe_d = 1'b0, r_isn = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Payout by value: as many dimes as stock allows, nickels for the rest
  function automatic void model_plan(input logic [2:0] code);
    int amt, nd, nn;
    if (code == 3'd0) return;
    if (code > 3'd4) begin exp_short++; return; end
    amt = 5 * int'(code);
    nd = amt / 10;
    if (nd > m_d) nd = m_d;
    nn = (amt - 10 * nd) / 5;
    if (nn > m_n) exp_short++;
    else begin
      exp_done++;
      repeat (nn) exp_q.push_back(0);
      repeat (nd) exp_q.push_back(1);
    end
  endfunction

  // Per-cycle checks
  initial forever begin
    @(negedge clock);
    if (reset) begin
      run_n = 0; run_d = 0;
    end else begin
      chk("both_eject", int'(eject_nickel & eject_dime), 0);
      if (eject_nickel) run_n++;
      else if (run_n > 0) begin
        chk("nickel_pulse_len", run_n, PULSE);
        if (exp_q.size() == 0) chk("unexpected_nickel", 1, 0);
        else chk("coin_kind_nickel", exp_q.pop_front(), 0);
        run_n = 0;
      end
      if (eject_dime) run_d++;
      else if (run_d > 0) begin
        chk("dime_pulse_len", run_d, PULSE);
        if (exp_q.size() == 0) chk("unexpected_dime", 1, 0);
        else chk("coin_kind_dime", exp_q.pop_front(), 1);
        run_d = 0;
      end
      if (done) done_cnt++;
      if (short_change) short_cnt++;
      chk("nickel_count", int'(nickel_count), m_n);
      chk("dime_count", int'(dime_count), m_d);
    end
  end

  // Chute sensor: answers two cycles after each pulse ends
  initial forever begin
    @(negedge clock);
    if (resp_en && !reset && ((pe_n && !eject_nickel) || (pe_d && !eject_dime))) begin
      r_isn = pe_n;
      repeat (2) @(posedge clock);
      #1;
      if (r_isn) nickel_drop = 1'b1; else dime_drop = 1'b1;
      @(posedge clock);
      if (r_isn) m_n--; else m_d--;
      #1;
      nickel_drop = 1'b0; dime_drop = 1'b0;
      pe_n = 1'b0; pe_d = 1'b0;
    end else begin
      pe_n = eject_nickel; pe_d = eject_dime;
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    m_n = NI; m_d = DI;
    exp_q.delete();
    exp_done = 0; exp_short = 0; done_cnt = 0; short_cnt = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Returns 1ns after the accepting edge
  task automatic request(input logic [2:0] code, input bit rf);
    @(posedge clock); #1;
    change = code; refill = rf;
    @(posedge clock);
    if (rf) begin m_n = NI; m_d = DI; end
    model_plan(code);
    #1;
    change = 3'd0; refill = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin @(negedge clock); n++; end
    if (busy) chk({tag, "_idle_timeout"}, 1, 0);
    @(negedge clock);
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
    chk({tag, "_short_cnt"}, short_cnt, exp_short);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_eject_nickel", int'(eject_nickel), 0);
    chk("rst_eject_dime", int'(eject_dime), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short", int'(short_change), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_nickel_count", int'(nickel_count), 20);
    chk("rst_dime_count", int'(dime_count), 20);

    // nickel then dime
    request(3'd3, 1'b0);
    chk("t1_busy", int'(busy), 1);
    wait_idle("t1");
    chk("t1_nickels", int'(nickel_count), 19);
    chk("t1_dimes", int'(dime_count), 19);
    chk("t1_done_once", done_cnt, 1);
    end_checks("t1");

    // drain dimes, then two dimes become four nickels
    do_reset();
    for (int i = 0; i < 10; i++) begin
      request(3'd4, 1'b0);
      wait_idle("drain");
    end
    chk("t2_dimes_empty", int'(dime_count), 0);
    request(3'd4, 1'b0);
    wait_idle("t2");
    chk("t2_nickels", int'(nickel_count), 16);
    chk("t2_dimes", int'(dime_count), 0);
    chk("t2_done", done_cnt, 11);
    end_checks("t2");

    // down to one nickel, no dimes: a dime request is unpayable
    for (int i = 0; i < 15; i++) begin
      request(3'd1, 1'b0);
      wait_idle("t3drain");
    end
    chk("t3_nickels_one", int'(nickel_count), 1);
    request(3'd2, 1'b0);
    chk("t3_short_pulse", int'(short_change), 1);
    chk("t3_short_busy", int'(busy), 0);
    chk("t3_short_eject", int'(eject_nickel | eject_dime), 0);
    @(posedge clock); #1;
    chk("t3_short_one_cycle", int'(short_change), 0);
    request(3'd5, 1'b0);
    chk("t3_invalid_short", int'(short_change), 1);
    chk("t3_invalid_busy", int'(busy), 0);
    repeat (2) @(negedge clock);
    chk("t3_counts_n", int'(nickel_count), 1);
    chk("t3_counts_d", int'(dime_count), 0);
    end_checks("t3");

    // refill in the same cycle as a request: plan uses reloaded stock
    request(3'd4, 1'b1);
    chk("t4_accepted", int'(eject_dime), 1);
    wait_idle("t4");
    chk("t4_nickels", int'(nickel_count), 20);
    chk("t4_dimes", int'(dime_count), 18);

    // request during a dispense is dropped and flagged
    chk("t5_overrun_before", int'(overrun), 0);
    request(3'd4, 1'b0);
    @(posedge clock); #1 change = 3'd1;
    @(posedge clock); #1 change = 3'd0;
    chk("t5_overrun", int'(overrun), 1);
    wait_idle("t5");
    chk("t5_dimes", int'(dime_count), 16);
    chk("t5_nickels", int'(nickel_count), 20);
    chk("t5_overrun_sticky", int'(overrun), 1);
    end_checks("t5");

    // sensor never answers: fault after 255 wait cycles
    do_reset();
    resp_en = 1'b0;
    request(3'd1, 1'b0);
    repeat (258) @(posedge clock);
    #1;
    chk("t6_fault_early", int'(fault), 0);
    chk("t6_busy_wait", int'(busy), 1);
    @(posedge clock); #1;
    chk("t6_fault", int'(fault), 1);
    chk("t6_busy", int'(busy), 1);
    chk("t6_eject", int'(eject_nickel | eject_dime), 0);
    refill = 1'b1;
    @(posedge clock); #1 refill = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("t6_fault_sticky", int'(fault), 1);
    chk("t6_eject_sticky", int'(eject_nickel | eject_dime), 0);
    chk("t6_nickels", int'(nickel_count), 20);

    // reset in the middle of a pulse
    do_reset();
    chk("t7_fault_cleared", int'(fault), 0);
    request(3'd3, 1'b0);
    @(posedge clock); #1;
    chk("t7_mid_pulse", int'(eject_nickel), 1);
    do_reset();
    chk("t7_eject", int'(eject_nickel | eject_dime), 0);
    chk("t7_busy", int'(busy), 0);
    chk("t7_nickels", int'(nickel_count), 20);
    chk("t7_dimes", int'(dime_count), 20);

    // normal operation after reset
    resp_en = 1'b1;
    request(3'd2, 1'b0);
    wait_idle("t8");
    chk("t8_dimes", int'(dime_count), 19);
    chk("t8_nickels", int'(nickel_count), 20);
    end_checks("t8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
